wptr_full_prog: RTL



---
 rtl/fifo_pkg.sv | 23 ++
 rtl/wptr_full_prog_if.sv | 30 +++
 rtl/gray2bin_conv.sv | 36 +++
 rtl/wptr_full_prog.sv | 86 ++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: depth derivation and Gray/binary conversion.
// Functions work on 32-bit vectors; callers cast down to their pointer width.
package fifo_pkg;

   function automatic int unsigned depth_of(int unsigned asize);
      return 32'd1 << asize;
   endfunction

   // Bits above the caller's width are zero, so a full-width prefix XOR is exact.
   function automatic logic [31:0] gray2bin(logic [31:0] gray);
      logic [31:0] bin;
      bin = '0;
      for (int i = 0; i < 32; i++) begin
         bin[i] = ^(gray >> i);
      end
      return bin;
   endfunction

   function automatic logic [31:0] bin2gray(logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/wptr_full_prog_if.sv
// Write-side FIFO control bundle: requests/config in, pointers and flags out.
interface wptr_full_prog_if #(
   parameter int unsigned ASIZE = 5
) ();

   logic             winc;
   logic [ASIZE:0]   wq2_rptr;
   logic [ASIZE:0]   waf_thresh;
   logic             waf_thresh_vld;
   logic             wovf_clr;
   logic [ASIZE-1:0] waddr;
   logic [ASIZE:0]   wptr;
   logic             wack;
   logic             wfull;
   logic             walmostfull;
   logic [ASIZE:0]   wlevel;
   logic [ASIZE:0]   wfree;
   logic             woverflow;

   modport master (
      output winc, wq2_rptr, waf_thresh, waf_thresh_vld, wovf_clr,
      input  waddr, wptr, wack, wfull, walmostfull, wlevel, wfree, woverflow
   );

   modport slave (
      input  winc, wq2_rptr, waf_thresh, waf_thresh_vld, wovf_clr,
      output waddr, wptr, wack, wfull, walmostfull, wlevel, wfree, woverflow
   );

endinterface

// File: rtl/gray2bin_conv.sv
// Gray-to-binary converter with an optional output register (shared by wptr/rptr blocks).
module gray2bin_conv
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH = 6,
   parameter bit          REG   = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   logic [WIDTH-1:0] bin_comb;

   assign bin_comb = WIDTH'(gray2bin(32'(gray)));

   if (REG) begin : g_reg
      logic [WIDTH-1:0] bin_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            bin_q <= '0;
         end else begin
            bin_q <= bin_comb;
         end
      end

      assign bin = bin_q;
   end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign bin = bin_comb;
   end

endmodule

// File: rtl/wptr_full_prog.sv
// Async-FIFO write pointer / full controller with programmable almost-full,
// fill-level/free-space outputs and sticky overflow.
module wptr_full_prog
   import fifo_pkg::*;
#(
   parameter int unsigned ASIZE      = 5,
   parameter int unsigned AF_DEFAULT = 4,
   parameter int unsigned RBIN_REG   = 0
) (
   input  logic            wclk,
   input  logic            wrst,
   wptr_full_prog_if.slave wif
);

   localparam int unsigned    PW      = ASIZE + 1;
   localparam int unsigned    DEPTH   = depth_of(ASIZE);
   localparam logic [ASIZE:0] DEPTH_W = PW'(DEPTH);
   localparam logic [ASIZE:0] AF_W    = PW'(AF_DEFAULT);

   logic [ASIZE:0] wbin_q, wptr_q, wlevel_q, wfree_q, thr_q;
   logic           wfull_q, waf_q, wovf_q;

   logic [ASIZE:0] wbinnext, wgraynext, rbin, levnext, freenext, thr_d;
   logic           wack, wfull_d, waf_d, wovf_d;

   gray2bin_conv #(
      .WIDTH (PW),
      .REG   (RBIN_REG != 0)
   ) u_rptr_conv (
      .clk  (wclk),
      .rst  (wrst),
      .gray (wif.wq2_rptr),
      .bin  (rbin)
   );

   // Modular subtraction keeps the level correct across pointer wrap.
   always_comb begin
      wack      = wif.winc & ~wfull_q;
      wbinnext  = wbin_q + {{ASIZE{1'b0}}, wack};
      wgraynext = PW'(bin2gray(32'(wbinnext)));
      levnext   = wbinnext - rbin;
      freenext  = DEPTH_W - levnext;
      wfull_d   = (levnext == DEPTH_W);
      waf_d     = (freenext <= thr_q);
      thr_d     = wif.waf_thresh_vld ? wif.waf_thresh : thr_q;
      wovf_d    = (wif.winc & wfull_q) | (wovf_q & ~wif.wovf_clr);
   end

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         wbin_q   <= '0;
         wptr_q   <= '0;
         wfull_q  <= 1'b0;
         waf_q    <= 1'b0;
         wlevel_q <= '0;
         wfree_q  <= DEPTH_W;
         wovf_q   <= 1'b0;
         thr_q    <= AF_W;
      end else begin
         wbin_q   <= wbinnext;
         wptr_q   <= wgraynext;
         wfull_q  <= wfull_d;
         waf_q    <= waf_d;
         wlevel_q <= levnext;
         wfree_q  <= freenext;
         wovf_q   <= wovf_d;
         thr_q    <= thr_d;
      end
   end

   assign wif.waddr       = wbin_q[ASIZE-1:0];
   assign wif.wptr        = wptr_q;
   assign wif.wack        = wack;
   assign wif.wfull       = wfull_q;
   assign wif.walmostfull = waf_q;
   assign wif.wlevel      = wlevel_q;
   assign wif.wfree       = wfree_q;
   assign wif.woverflow   = wovf_q;

   // The level-based full must agree with the classic Gray-pointer compare.
   if (ASIZE >= 2 && RBIN_REG == 0) begin : g_full_chk
      full_matches_gray : assert property (@(posedge wclk) disable iff (wrst)
         wfull_d == (wgraynext == {~wif.wq2_rptr[ASIZE:ASIZE-1], wif.wq2_rptr[ASIZE-2:0]}));
   end

endmodule
